fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
Instruction-fetch front end of the DLX pipeline and consumer of the ID-stage jump/branch redirect (take/target pair plus PC+4 link base). Owns the architectural PC, issues requests to instruction memory with a ready handshake, and drives the IF/ID pipeline register. Applies branch/jump redirects by squashing the in-flight fetch and flushing IF/ID.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word driven into IF/ID on flush or bubble

Ports:
clk  in  1  pipeline clock, all state on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
stall  in  1  hazard unit: hold IF/ID and PC
take_branch  in  1  ID-stage redirect request; qualified, single-cycle
branch_target  in  32  redirect PC (jump/branch target or jr register value)
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address, equals PC
imem_ready  in  1  memory returns imem_rdata this cycle
imem_rdata  in  32  fetched instruction word
if_valid  out  1  IF/ID holds a real instruction
if_instr  out  32  IF/ID instruction
if_pc_plus_four  out  32  IF/ID PC+4 (branch base and link value for jal)
flush_if  out  1  registered one-cycle pulse: IF/ID squashed by redirect
align_err  out  1  registered one-cycle pulse: redirect target not word aligned

Behaviour:
- Reset (rst_n=0 at edge): pc=RESET_PC; state=BOOT; if_valid=0; if_instr=NOP_INSTR; if_pc_plus_four=0; flush_if=0; align_err=0; buffer empty. imem_req=0 while in reset and in BOOT.
- imem_addr = pc (combinational). imem_req = 1 only in FETCH.
- States: BOOT, FETCH, HOLD.
- BOOT: next state always FETCH, one cycle after reset release. take_branch in BOOT is ignored.
- FETCH with imem_ready=1, stall=0: if_instr<=imem_rdata; if_pc_plus_four<=pc+4; if_valid<=1; pc<=pc+4; stay in FETCH. Throughput is 1 instruction/cycle with zero-wait memory.
- FETCH with imem_ready=1, stall=1: capture {imem_rdata, pc+4} into the 1-entry hold buffer; IF/ID is unchanged; pc is unchanged; go to HOLD.
- FETCH with imem_ready=0: if stall=0, insert a bubble (if_valid<=0, if_instr<=NOP_INSTR); if stall=1, IF/ID holds. pc is unchanged.
- HOLD: imem_req=0. While stall=1, everything holds. On stall=0, load IF/ID from the buffer (if_valid<=1), set pc<=buffered pc+4, and go to FETCH.
- Redirect (take_branch=1) has highest priority over stall, imem_ready and state (except BOOT/reset):
  - pc<=branch_target with bits [1:0] forced to 00.
  - align_err<=1 if branch_target[1:0]!=0.
  - if_valid<=0; if_instr<=NOP_INSTR; if_pc_plus_four<=0; flush_if<=1.
  - Hold buffer is discarded. Any imem_rdata accepted in the same cycle is discarded. Next state is FETCH.
- flush_if and align_err are 0 in every cycle that does not follow a redirect. Back-to-back redirects produce back-to-back pulses, and the last target wins.
- PC arithmetic is 32-bit modulo: pc+4 from 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- Reset mid-fetch drops the outstanding request. Memory must tolerate imem_req falling without an imem_ready.
- Reset has priority over all inputs, including take_branch.

Test Plan:
- Reset with RESET_PC=0, then rst_n=1, imem_ready=1 constant, data=addr -> imem_req first high 1 cycle after release. IF/ID carries (0,4), (4,8), (8,12) with if_valid=1 on consecutive cycles.
- Redirect: take_branch=1, target=32'h0000_0100 while fetching 0x10 -> flush_if=1 next cycle, if_valid=0, if_instr=NOP_INSTR. Next imem_addr=0x100, and 0x10's data never appears in IF/ID.
- Stall: stall=1 for 3 cycles with imem_ready=1 at pc=0x20 -> state HOLD, imem_req=0, IF/ID unchanged. After release, IF/ID=(rdata@0x20, 0x24) and pc=0x24.
- Redirect during HOLD with stall=1: target=0x200 -> buffer dropped, flush_if pulse, next fetch at 0x200.
- Misaligned target 0x103 -> pc=0x100, align_err=1 for exactly one cycle. Separately, pc=0xFFFFFFFC fetch -> if_pc_plus_four=0 and next imem_addr=0.
- imem_ready low 2 cycles with stall=0 -> two bubbles (if_valid=0) and imem_addr held. rst_n=0 mid-wait -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the architectural PC, issues instruction
// memory requests with a ready handshake, and drives the IF/ID register.
// An ID-stage redirect squashes the in-flight fetch and flushes IF/ID.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        take_branch,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus_four,
    output logic        flush_if,
    output logic        align_err
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_HOLD
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_pc4;
    logic        r_if_valid;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc4;
    logic        r_flush;
    logic        r_align;

    logic [31:0] w_pc_plus_four;
    logic        w_redirect;

    assign w_pc_plus_four = r_pc + 32'd4;
    // Redirects are ignored in BOOT; the pipeline has nothing to squash yet.
    assign w_redirect     = take_branch && (r_state != S_BOOT);

    // Requests only go out from FETCH; gating with rst_n drops any
    // outstanding request as soon as reset is asserted.
    assign imem_req        = rst_n && (r_state == S_FETCH);
    assign imem_addr       = r_pc;
    assign if_valid        = r_if_valid;
    assign if_instr        = r_if_instr;
    assign if_pc_plus_four = r_if_pc4;
    assign flush_if        = r_flush;
    assign align_err       = r_align;

    // PC, fetch state machine, hold buffer and IF/ID register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_BOOT;
            r_pc        <= RESET_PC;
            r_buf_instr <= NOP_INSTR;
            r_buf_pc4   <= '0;
            r_if_valid  <= 1'b0;
            r_if_instr  <= NOP_INSTR;
            r_if_pc4    <= '0;
            r_flush     <= 1'b0;
            r_align     <= 1'b0;
        end else begin
            r_flush <= 1'b0;
            r_align <= 1'b0;
            if (w_redirect) begin
                // Redirect beats stall, ready and the hold buffer: any data
                // returned this cycle and any buffered word are dropped.
                r_pc       <= {branch_target[31:2], 2'b00};
                r_align    <= |branch_target[1:0];
                r_if_valid <= 1'b0;
                r_if_instr <= NOP_INSTR;
                r_if_pc4   <= '0;
                r_flush    <= 1'b1;
                r_state    <= S_FETCH;
            end else begin
                case (r_state)
                    S_BOOT: begin
                        r_state <= S_FETCH;
                    end
                    S_FETCH: begin
                        if (imem_ready) begin
                            if (!stall) begin
                                r_if_valid <= 1'b1;
                                r_if_instr <= imem_rdata;
                                r_if_pc4   <= w_pc_plus_four;
                                r_pc       <= w_pc_plus_four;
                            end else begin
                                // Word arrived while ID is stalled: park it so
                                // the fetch is not repeated.
                                r_buf_instr <= imem_rdata;
                                r_buf_pc4   <= w_pc_plus_four;
                                r_state     <= S_HOLD;
                            end
                        end else if (!stall) begin
                            r_if_valid <= 1'b0;
                            r_if_instr <= NOP_INSTR;
                        end
                    end
                    S_HOLD: begin
                        if (!stall) begin
                            r_if_valid <= 1'b1;
                            r_if_instr <= r_buf_instr;
                            r_if_pc4   <= r_buf_pc4;
                            r_pc       <= r_buf_pc4;
                            r_state    <= S_FETCH;
                        end
                    end
                    default: begin
                        r_state <= S_BOOT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: the stimulus thread pushes the IF/ID
// contents each delivered instruction should produce; a monitor pops and
// compares whenever IF/ID is freshly loaded with a valid instruction.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        take_branch;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus_four;
    logic        flush_if;
    logic        align_err;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];
    logic        stall_q = 1'b1;

    fetch_pc_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .take_branch    (take_branch),
        .branch_target  (branch_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc_plus_four(if_pc_plus_four),
        .flush_if       (flush_if),
        .align_err      (align_err)
    );

    always #5 clk = ~clk;

    // Memory model: word at address A reads as A + 0x1000_0000.
    assign imem_rdata = imem_addr + 32'h1000_0000;

    // Stall as seen by the DUT at the edge: IF/ID is held when it was high.
    always @(posedge clk) stall_q <= stall;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc4);
        exp_q.push_back({instr, pc4});
    endtask

    // Monitor: each freshly loaded valid IF/ID entry is matched in order.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && if_valid === 1'b1 && stall_q === 1'b0) begin
            if (exp_q.size() == 0) begin
                check("ifid_unexpected", {if_instr, if_pc_plus_four}, 64'hxxxx_xxxx_xxxx_xxxx);
            end else begin
                check("ifid_entry", {if_instr, if_pc_plus_four}, exp_q.pop_front());
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; take_branch = 1'b0;
        branch_target = 32'h0; imem_ready = 1'b1;
        cyc(2);
        check("rst_valid", {63'd0, if_valid}, 64'd0);
        check("rst_instr", {32'd0, if_instr}, 64'd0);
        check("rst_pc4",   {32'd0, if_pc_plus_four}, 64'd0);
        check("rst_flags", {62'd0, flush_if, align_err}, 64'd0);
        check("rst_req",   {63'd0, imem_req}, 64'd0);
        check("rst_addr",  {32'd0, imem_addr}, 64'd0);

        // Boot and sequential fetch with zero-wait memory.
        rst_n = 1'b1;
        #1;
        check("boot_req_low", {63'd0, imem_req}, 64'd0);
        cyc(1);
        check("boot_req_high", {63'd0, imem_req}, 64'd1);
        push(32'h1000_0000, 32'h4);
        push(32'h1000_0004, 32'h8);
        push(32'h1000_0008, 32'hC);
        push(32'h1000_000C, 32'h10);
        cyc(4);
        check("seq_addr", {32'd0, imem_addr}, 64'h10);

        // Redirect while fetching 0x10: its data must never reach IF/ID.
        take_branch = 1'b1; branch_target = 32'h0000_0100;
        cyc(1);
        take_branch = 1'b0;
        check("br_flush", {63'd0, flush_if}, 64'd1);
        check("br_valid", {63'd0, if_valid}, 64'd0);
        check("br_instr", {32'd0, if_instr}, 64'd0);
        check("br_addr",  {32'd0, imem_addr}, 64'h100);
        check("br_align", {63'd0, align_err}, 64'd0);
        push(32'h1000_0100, 32'h104);
        cyc(1);
        check("br_flush_end", {63'd0, flush_if}, 64'd0);

        // Move to 0x1C, deliver it, then stall 3 cycles with pc=0x20.
        take_branch = 1'b1; branch_target = 32'h0000_001C;
        cyc(1);
        take_branch = 1'b0;
        push(32'h1000_001C, 32'h20);
        cyc(1);
        stall = 1'b1;
        cyc(1);
        check("hold_req", {63'd0, imem_req}, 64'd0);
        check("hold_ifid", {if_instr, if_pc_plus_four}, {32'h1000_001C, 32'h20});
        cyc(2);
        check("hold_ifid_3", {if_instr, if_pc_plus_four}, {32'h1000_001C, 32'h20});
        check("hold_addr", {32'd0, imem_addr}, 64'h20);
        stall = 1'b0;
        push(32'h1000_0020, 32'h24);
        cyc(1);
        check("unhold_addr", {32'd0, imem_addr}, 64'h24);
        check("unhold_req", {63'd0, imem_req}, 64'd1);

        // Redirect while in HOLD with stall still high: buffer is dropped.
        stall = 1'b1;
        cyc(1);
        take_branch = 1'b1; branch_target = 32'h0000_0200;
        cyc(1);
        take_branch = 1'b0; stall = 1'b0;
        check("hbr_flush", {63'd0, flush_if}, 64'd1);
        check("hbr_valid", {63'd0, if_valid}, 64'd0);
        check("hbr_addr",  {32'd0, imem_addr}, 64'h200);
        check("hbr_req",   {63'd0, imem_req}, 64'd1);
        push(32'h1000_0200, 32'h204);
        cyc(1);
        check("hbr_flush_end", {63'd0, flush_if}, 64'd0);

        // Misaligned target: low bits cleared, one-cycle align_err.
        take_branch = 1'b1; branch_target = 32'h0000_0103;
        cyc(1);
        take_branch = 1'b0;
        check("mis_align", {63'd0, align_err}, 64'd1);
        check("mis_addr",  {32'd0, imem_addr}, 64'h100);
        push(32'h1000_0100, 32'h104);
        cyc(1);
        check("mis_align_end", {62'd0, align_err, flush_if}, 64'd0);

        // PC wrap from 0xFFFF_FFFC.
        take_branch = 1'b1; branch_target = 32'hFFFF_FFFC;
        cyc(1);
        take_branch = 1'b0;
        push(32'h0FFF_FFFC, 32'h0);
        cyc(1);
        check("wrap_pc4",  {32'd0, if_pc_plus_four}, 64'h0);
        check("wrap_addr", {32'd0, imem_addr}, 64'h0);

        // Memory not ready for 2 cycles: two bubbles, address held.
        imem_ready = 1'b0;
        cyc(1);
        check("bub1_valid", {63'd0, if_valid}, 64'd0);
        check("bub1_instr", {32'd0, if_instr}, 64'd0);
        cyc(1);
        check("bub2_valid", {63'd0, if_valid}, 64'd0);
        check("bub2_addr",  {32'd0, imem_addr}, 64'h0);

        // Reset in the middle of the wait.
        take_branch = 1'b1; branch_target = 32'h0000_0400;
        #1;
        rst_n = 1'b0;
        cyc(1);
        take_branch = 1'b0;
        check("mrst_req",   {63'd0, imem_req}, 64'd0);
        check("mrst_addr",  {32'd0, imem_addr}, 64'h0);
        check("mrst_ifid",  {31'd0, if_valid, if_instr}, 64'd0);
        check("mrst_pc4",   {32'd0, if_pc_plus_four}, 64'd0);
        check("mrst_flags", {62'd0, flush_if, align_err}, 64'd0);

        // Restart after reset.
        rst_n = 1'b1; imem_ready = 1'b1;
        push(32'h1000_0000, 32'h4);
        cyc(2);
        imem_ready = 1'b0;
        cyc(2);
        check("queue_drained", {32'd0, exp_q.size()}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
